// File: rtl/display_framebuffer_pkg.sv
// ============================================================================
// display_framebuffer_pkg
// Shared pixel/address helpers and the bank-swap state type for the framebuffer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package display_framebuffer_pkg;

    typedef enum logic [0:0] {
        ST_FILL    = 1'b0,
        ST_PENDING = 1'b1
    } swap_state_e;

    function automatic int pixel_width(input int bitwidth);
        return 3 * bitwidth;
    endfunction

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fb_ram.sv
// ============================================================================
// fb_ram
// Simple dual-port RAM: one write port, one registered read port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fb_ram #(
    parameter int DW = 24,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Only the output register is reset; array contents survive reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/display_framebuffer.sv
// ============================================================================
// display_framebuffer
// Double-buffered pixel store: stream writes into the back bank, display reads
// the front bank, banks swap on commit at a safe flip point.
// Revision: 1.0
// ============================================================================
`default_nettype none

module display_framebuffer
    import display_framebuffer_pkg::*;
#(
    parameter int SEGMENTS = 1,
    parameter int ROWS     = 8,
    parameter int COLUMNS  = 32,
    parameter int BITWIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [$clog2(ROWS)-1:0]        rd_row,
    input  logic [$clog2(COLUMNS)-1:0]     rd_column,
    output logic [SEGMENTS*3*BITWIDTH-1:0] rd_pixel,
    input  logic                           frame_complete,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    input  logic [3*BITWIDTH-1:0]          wr_data,
    input  logic                           wr_start,
    input  logic                           wr_commit,
    output logic                           swap_pending,
    output logic                           swap_done,
    output logic                           front_bank
);

    localparam int c_P    = pixel_width(BITWIDTH);
    localparam int c_RW   = $clog2(ROWS);
    localparam int c_CW   = $clog2(COLUMNS);
    localparam int c_LAW  = c_RW + c_CW;
    localparam int c_N    = SEGMENTS * ROWS * COLUMNS;
    localparam int c_PTRW = addr_width(c_N);

    swap_state_e       r_state;
    logic              r_front_bank;
    logic              r_swap_done;
    logic              r_live;
    logic [c_PTRW-1:0] r_wr_ptr;

    logic w_accept;
    logic w_swap;
    logic w_ptr_last;

    assign wr_ready   = r_live & ~rst & (r_state == ST_FILL);
    assign w_accept   = wr_valid & wr_ready;
    // A commit arriving together with frame_complete flips in the same cycle.
    assign w_swap     = frame_complete & ((r_state == ST_PENDING) | wr_commit);
    assign w_ptr_last = (r_wr_ptr == c_PTRW'(c_N - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_FILL;
            r_front_bank <= 1'b0;
            r_swap_done  <= 1'b0;
            r_live       <= 1'b0;
            r_wr_ptr     <= '0;
        end else begin
            r_live      <= 1'b1;
            r_swap_done <= w_swap;
            if (w_swap) begin
                r_front_bank <= ~r_front_bank;
                r_state      <= ST_FILL;
                r_wr_ptr     <= '0;
            end else begin
                if (wr_commit) begin
                    r_state <= ST_PENDING;
                end
                if (wr_start) begin
                    r_wr_ptr <= '0;
                end else if (w_accept) begin
                    r_wr_ptr <= w_ptr_last ? '0 : r_wr_ptr + c_PTRW'(1);
                end
            end
        end
    end

    // One RAM per segment; the bank select is the RAM address MSB.
    for (genvar s = 0; s < SEGMENTS; s++) begin : g_seg
        logic w_we;

        if (SEGMENTS == 1) begin : g_single
            assign w_we = w_accept;
        end else begin : g_multi
            assign w_we = w_accept && (r_wr_ptr[c_PTRW-1:c_LAW] == (c_PTRW-c_LAW)'(s));
        end

        fb_ram #(
            .DW (c_P),
            .AW (c_LAW + 1)
        ) u_ram (
            .clk     (clk),
            .rst     (rst),
            .i_we    (w_we),
            .i_waddr ({~r_front_bank, r_wr_ptr[c_LAW-1:0]}),
            .i_wdata (wr_data),
            .i_raddr ({r_front_bank, rd_row, rd_column}),
            .o_rdata (rd_pixel[s*c_P +: c_P])
        );
    end

    assign swap_pending = (r_state == ST_PENDING);
    assign swap_done    = r_swap_done;
    assign front_bank   = r_front_bank;

endmodule

`default_nettype wire

// File: tb/tb_display_framebuffer.sv
// ============================================================================
// tb_display_framebuffer
// Directed bench with a read scoreboard for display_framebuffer.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_display_framebuffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  rd_row = '0;
    logic [4:0]  rd_column = '0;
    logic [23:0] rd_pixel;
    logic        frame_complete = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [23:0] wr_data = '0;
    logic        wr_start = 1'b0;
    logic        wr_commit = 1'b0;
    logic        swap_pending;
    logic        swap_done;
    logic        front_bank;

    display_framebuffer #(
        .SEGMENTS (1),
        .ROWS     (8),
        .COLUMNS  (32),
        .BITWIDTH (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rd_row         (rd_row),
        .rd_column      (rd_column),
        .rd_pixel       (rd_pixel),
        .frame_complete (frame_complete),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_data        (wr_data),
        .wr_start       (wr_start),
        .wr_commit      (wr_commit),
        .swap_pending   (swap_pending),
        .swap_done      (swap_done),
        .front_bank     (front_bank)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [23:0] exp;
    } rd_exp_t;

    rd_exp_t exp_q[$];
    int      n_checks = 0;
    int      n_pass = 0;
    int      swap_done_cnt = 0;
    logic    rd_issue = 1'b0;
    logic    rd_vld_d = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Read data is due one cycle after the address is sampled.
    always @(posedge clk) rd_vld_d <= rd_issue;

    always @(negedge clk) begin
        rd_exp_t e;
        if (swap_done === 1'b1) swap_done_cnt++;
        if (rd_vld_d) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL rd_unexpected: got %h expected no read", rd_pixel);
            end else begin
                e = exp_q.pop_front();
                check(e.name, {8'h0, rd_pixel}, {8'h0, e.exp});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_beat(input logic [23:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic read_addr(input string nm, input int a, input logic [23:0] e);
        rd_exp_t item;
        rd_row    = 3'(a / 32);
        rd_column = 5'(a % 32);
        rd_issue  = 1'b1;
        item.name = nm;
        item.exp  = e;
        exp_q.push_back(item);
        tick();
        rd_issue = 1'b0;
    endtask

    task automatic swap_now();
        wr_commit      = 1'b1;
        frame_complete = 1'b1;
        tick();
        wr_commit      = 1'b0;
        frame_complete = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt0;

        // Reset state
        repeat (3) tick();
        check("rst_wr_ready", {31'h0, wr_ready}, 32'h0);
        check("rst_rd_pixel", {8'h0, rd_pixel}, 32'h0);
        check("rst_front", {31'h0, front_bank}, 32'h0);
        check("rst_pending", {31'h0, swap_pending}, 32'h0);
        check("rst_done", {31'h0, swap_done}, 32'h0);
        rst = 1'b0;
        tick();
        check("post_rst_wr_ready", {31'h0, wr_ready}, 32'h1);

        // Full frame into bank 1, commit, flip
        for (int i = 0; i < 256; i++) write_beat(24'(i));
        wr_commit = 1'b1;
        tick();
        wr_commit = 1'b0;
        check("commit_pending", {31'h0, swap_pending}, 32'h1);
        check("commit_ready", {31'h0, wr_ready}, 32'h0);
        frame_complete = 1'b1;
        tick();
        frame_complete = 1'b0;
        check("flip1_done", {31'h0, swap_done}, 32'h1);
        check("flip1_front", {31'h0, front_bank}, 32'h1);
        check("flip1_pending", {31'h0, swap_pending}, 32'h0);
        tick();
        check("flip1_done_clr", {31'h0, swap_done}, 32'h0);
        read_addr("rd_r3c5", 101, 24'h000065);
        read_addr("rd_r0c0", 0, 24'h000000);
        read_addr("rd_r7c31", 255, 24'h0000FF);

        // Bank 0 frame, then a long-held commit with writes blocked
        for (int i = 0; i < 256; i++) write_beat(24'hA00000 | 24'(i));
        wr_commit = 1'b1;
        tick();
        wr_commit = 1'b0;
        wr_valid  = 1'b1;
        wr_data   = 24'hDEAD00;
        repeat (1000) tick();
        check("hold_pending", {31'h0, swap_pending}, 32'h1);
        check("hold_ready", {31'h0, wr_ready}, 32'h0);
        check("hold_front", {31'h0, front_bank}, 32'h1);
        read_addr("hold_rd_front", 101, 24'h000065);
        wr_valid = 1'b0;
        frame_complete = 1'b1;
        tick();
        frame_complete = 1'b0;
        check("flip2_front", {31'h0, front_bank}, 32'h0);
        check("flip2_done", {31'h0, swap_done}, 32'h1);
        tick();
        read_addr("b0_addr0", 0, 24'hA00000);
        read_addr("b0_addr101", 101, 24'hA00065);
        read_addr("b0_addr255", 255, 24'hA000FF);

        // Commit coincident with frame_complete, held 5 cycles
        for (int i = 0; i < 4; i++) write_beat(24'hB00000 | 24'(i));
        cnt0 = swap_done_cnt;
        wr_commit      = 1'b1;
        frame_complete = 1'b1;
        tick();
        wr_commit = 1'b0;
        check("coin_front", {31'h0, front_bank}, 32'h1);
        check("coin_pending", {31'h0, swap_pending}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("coin_hold_pending", {31'h0, swap_pending}, 32'h0);
            check("coin_hold_front", {31'h0, front_bank}, 32'h1);
        end
        frame_complete = 1'b0;
        tick();
        tick();
        check("coin_one_swap", 32'(swap_done_cnt - cnt0), 32'h1);
        read_addr("coin_addr0", 0, 24'hB00000);
        read_addr("coin_addr3", 3, 24'hB00003);
        read_addr("coin_addr4", 4, 24'h000004);

        // Pointer wrap: 260 beats into bank 0
        for (int i = 0; i < 260; i++) write_beat(24'hC00000 + 24'(i));
        swap_now();
        check("wrap_front", {31'h0, front_bank}, 32'h0);
        read_addr("wrap_addr0", 0, 24'hC00100);
        read_addr("wrap_addr3", 3, 24'hC00103);
        read_addr("wrap_addr4", 4, 24'hC00004);
        read_addr("wrap_addr255", 255, 24'hC000FF);

        // wr_start coincident with beat 11
        for (int i = 0; i < 10; i++) write_beat(24'hD00000 | 24'(i));
        wr_start = 1'b1;
        write_beat(24'hD0000A);
        wr_start = 1'b0;
        write_beat(24'hE00000);
        swap_now();
        read_addr("start_addr0", 0, 24'hE00000);
        read_addr("start_addr1", 1, 24'hD00001);
        read_addr("start_addr10", 10, 24'hD0000A);
        read_addr("start_addr11", 11, 24'h00000B);

        // Reset while a swap is pending
        swap_now();
        for (int i = 0; i < 3; i++) write_beat(24'hF00000 | 24'(i));
        wr_commit = 1'b1;
        tick();
        wr_commit = 1'b0;
        check("pre_rst_pending", {31'h0, swap_pending}, 32'h1);
        rst = 1'b1;
        tick();
        tick();
        check("mid_rst_front", {31'h0, front_bank}, 32'h0);
        check("mid_rst_pending", {31'h0, swap_pending}, 32'h0);
        check("mid_rst_pixel", {8'h0, rd_pixel}, 32'h0);
        check("mid_rst_ready", {31'h0, wr_ready}, 32'h0);
        rst = 1'b0;
        tick();
        check("post_rst2_ready", {31'h0, wr_ready}, 32'h1);
        write_beat(24'h123456);
        swap_now();
        check("post_rst2_front", {31'h0, front_bank}, 32'h1);
        read_addr("rst_addr0", 0, 24'h123456);
        read_addr("rst_addr1", 1, 24'hF00001);
        read_addr("rst_addr2", 2, 24'hF00002);
        read_addr("rst_addr3", 3, 24'hD00003);

        repeat (3) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
